cal_sync_fifo_param: RTL
========================

Name: cal_sync_fifo_param

Overview:
Parametrised single-clock synchronous FIFO for calibrator averaging and data paths. It is the successor to the fixed 512x32 averaging-data FIFO and generalises it in width and depth. It adds a selectable show-ahead (FWFT) mode, programmable almost-full and almost-empty flags, an occupancy count, sticky overflow and underflow flags, a read-data-valid strobe and a synchronous flush. It sits between the calibrator accumulators and downstream readout/packetiser logic.

Parameters:
WIDTH, 32, data word width in bits (1..64)
DEPTH, 512, capacity in words; power of two, 4..4096
AFULL_VAL, 480, AFULL asserted when COUNT >= AFULL_VAL (1..DEPTH-1)
AEMPTY_VAL, 4, AEMPTY asserted when COUNT <= AEMPTY_VAL (0..DEPTH-2)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
CLK  in  1  single clock; all logic on rising edge
RESET  in  1  synchronous reset, active-high
FLUSH  in  1  synchronous clear of contents and sticky flags; RESET takes priority
DATA  in  WIDTH  write data
WE  in  1  write request, active-high
RE  in  1  read request (standard) / pop (FWFT), active-high
Q  out  WIDTH  read data
DVLD  out  1  standard: 1-cycle pulse, Q valid; FWFT: level, Q holds head word
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  no word readable
AFULL  out  1  COUNT >= AFULL_VAL
AEMPTY  out  1  COUNT <= AEMPTY_VAL
COUNT  out  clog2(DEPTH)+1  words held, including the FWFT output stage
OVERFLOW  out  1  sticky: WE seen while FULL
UNDERFLOW  out  1  sticky: RE seen while EMPTY

Behaviour:
- Reset/flush values: Q=0, DVLD=0, FULL=0, EMPTY=1, AFULL=0, AEMPTY=1, COUNT=0, OVERFLOW=0, UNDERFLOW=0. Pointers cleared. Memory contents are not cleared. Reset is honoured mid-transfer; any in-flight read is dropped.
- Write accept: wr_ok = WE & ~FULL, using the FULL value of the current cycle. DATA is stored at wr_ptr. wr_ptr increments and wraps modulo DEPTH.
- WE & FULL: write dropped, contents unchanged, OVERFLOW set (sticky).
- RE & EMPTY: read dropped, Q unchanged, UNDERFLOW set (sticky).
- All flags and COUNT are registered and update on the same edge as the accepted access.
- COUNT update: +1 on write only, -1 on read only, unchanged on simultaneous write+read.
- Simultaneous WE&RE at FULL: read accepted, write dropped, OVERFLOW set, COUNT = DEPTH-1.
- Simultaneous WE&RE at EMPTY: write accepted, read dropped, UNDERFLOW set, COUNT = 1.
- Standard mode (FWFT=0): rd_ok = RE & ~EMPTY. Q is loaded from mem[rd_ptr] and DVLD pulses high one cycle after the RE cycle (latency 1). Q holds its value between reads. EMPTY deasserts on the edge that accepts the first write.
- FWFT mode (FWFT=1): the output register holds the head word. DVLD = ~EMPTY.
  - A word written into an empty FIFO at edge N appears on Q with EMPTY=0 after edge N+1 (prefetch cycle). COUNT=1 after edge N.
  - RE with DVLD=1 pops the head. The next word is on Q after the same edge if the memory is non-empty; otherwise EMPTY=1 and Q holds the stale value.
  - Back-to-back pops at one word per cycle are sustained with no bubbles while COUNT >= 2.
- Capacity is exactly DEPTH words in both modes.
- AFULL and AEMPTY are pure functions of registered COUNT; they are never glitched by dropped accesses.
- FLUSH & WE in the same cycle: the write is discarded.
- Memory must infer LSRAM/uSRAM: one write port, one read port, no reset on the array.

Test Plan:
1. WIDTH=32, DEPTH=8, FWFT=0. Write 0x11..0x18 on 8 consecutive cycles -> FULL=1 and COUNT=8 after the 8th edge, AFULL per AFULL_VAL=6 asserted after the 6th edge. Then 8 reads -> Q=0x11..0x18 each one cycle after RE, with DVLD pulsing each cycle; EMPTY=1 after the last read.
2. Full FIFO, WE=1 with DATA=0xDEAD -> OVERFLOW=1 and held; contents intact, so a readout returns 0x11..0x18. Empty FIFO, RE=1 -> UNDERFLOW=1, Q unchanged.
3. COUNT=8 with WE&RE together -> COUNT=7, OVERFLOW=1. COUNT=0 with WE&RE together -> COUNT=1, UNDERFLOW=1, DVLD stays 0.
4. FWFT=1. Single write of 0xA5 at edge N -> Q=0xA5, EMPTY=0 after edge N+1. Continuous streaming of 100 words with WE=RE=1 -> output order preserved, no loss, pointers wrap 12 times.
5. Half-full (COUNT=4) plus FLUSH -> COUNT=0, EMPTY=1, sticky flags cleared. RESET and FLUSH together -> same values.
6. RESET asserted for 1 cycle mid-burst (COUNT=5, RE active) -> all outputs at reset values on the next cycle. The next write/read pair returns the newly written word.

Source files
------------

// File: rtl/cal_sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : cal_sync_fifo_param_if
//  Purpose  : Bus bundle for cal_sync_fifo_param. Carries the write/read
//             requests, the synchronous flush, read data and all status flags.
//  Modports : master - producer/consumer side (drives FLUSH, DATA, WE, RE)
//             slave  - FIFO side (drives Q, DVLD, FULL, EMPTY, AFULL, AEMPTY,
//                      COUNT, OVERFLOW, UNDERFLOW)
//  Revision : 1.0 - initial release
// ============================================================================
interface cal_sync_fifo_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) ();
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic             FLUSH;
    logic [WIDTH-1:0] DATA;
    logic             WE;
    logic             RE;
    logic [WIDTH-1:0] Q;
    logic             DVLD;
    logic             FULL;
    logic             EMPTY;
    logic             AFULL;
    logic             AEMPTY;
    logic [c_CW-1:0]  COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output FLUSH, DATA, WE, RE,
        input  Q, DVLD, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  FLUSH, DATA, WE, RE,
        output Q, DVLD, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
    );
endinterface
`default_nettype wire

// File: rtl/cal_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : cal_sync_fifo_param
//  Purpose  : Parametrised single-clock FIFO with standard (registered read)
//             or first-word-fall-through output, programmable almost flags,
//             occupancy count, sticky overflow/underflow and synchronous flush.
//  Ports    : CLK   - clock, rising edge
//             RESET - synchronous reset, active-high (priority over FLUSH)
//             bus   - cal_sync_fifo_param_if.slave (FLUSH, DATA, WE, RE in;
//                     Q, DVLD, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW,
//                     UNDERFLOW out)
//  Revision : 1.0 - initial release
// ============================================================================
module cal_sync_fifo_param #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 512,
    parameter int AFULL_VAL  = 480,
    parameter int AEMPTY_VAL = 4,
    parameter int FWFT       = 0
) (
    input  wire logic                  CLK,
    input  wire logic                  RESET,
    cal_sync_fifo_param_if.slave       bus
);
    localparam int              c_AW  = $clog2(DEPTH);
    localparam int              c_CW  = c_AW + 1;
    localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

    // Storage array: no reset so it maps onto block/micro SRAM.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_nxt;
    logic             r_full;
    logic             r_afull;
    logic             r_aempty;
    logic             r_ovf;
    logic             r_udf;

    logic             w_clr;      // reset or flush
    logic             w_empty;    // "no word readable", mode dependent
    logic             w_wr_ok;    // write accepted
    logic             w_rd_ok;    // read / pop accepted
    logic             w_mem_rd;   // memory read this cycle (advances rd_ptr)

    assign w_clr   = RESET | bus.FLUSH;
    assign w_wr_ok = bus.WE & ~r_full & ~w_clr;
    assign w_rd_ok = bus.RE & ~w_empty & ~w_clr;

    // COUNT covers the memory plus the FWFT output stage, so a simultaneous
    // accepted write and read leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + c_ONE;
        end else if (!w_wr_ok && w_rd_ok) begin
            w_count_nxt = r_count - c_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= bus.DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_mem_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == c_CW'(DEPTH));
            r_afull  <= (w_count_nxt >= c_CW'(AFULL_VAL));
            r_aempty <= (w_count_nxt <= c_CW'(AEMPTY_VAL));
            if (bus.WE && r_full) begin
                r_ovf <= 1'b1;
            end
            if (bus.RE && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic [WIDTH-1:0] r_q;
            logic             r_ovld;   // output stage holds the head word
            logic             w_mem_nz; // words remain behind the output stage

            assign w_mem_nz = (r_count != {{(c_CW-1){1'b0}}, r_ovld});
            // Refill the output stage when it is empty or being popped.
            assign w_mem_rd = w_mem_nz & (~r_ovld | w_rd_ok) & ~w_clr;

            always_ff @(posedge CLK) begin
                if (w_clr) begin
                    r_q    <= '0;
                    r_ovld <= 1'b0;
                end else if (w_mem_rd) begin
                    r_q    <= r_mem[r_rd_ptr];
                    r_ovld <= 1'b1;
                end else if (w_rd_ok) begin
                    r_ovld <= 1'b0;  // popped last word; Q keeps stale value
                end
            end

            assign w_empty = ~r_ovld;
            assign bus.Q    = r_q;
            assign bus.DVLD = r_ovld;
        end else begin : g_std
            logic [WIDTH-1:0] r_q;
            logic             r_dvld;
            logic             r_empty;

            assign w_mem_rd = w_rd_ok;

            always_ff @(posedge CLK) begin
                if (w_clr) begin
                    r_q     <= '0;
                    r_dvld  <= 1'b0;
                    r_empty <= 1'b1;
                end else begin
                    r_dvld  <= w_rd_ok;
                    r_empty <= (w_count_nxt == '0);
                    if (w_rd_ok) begin
                        r_q <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign w_empty  = r_empty;
            assign bus.Q    = r_q;
            assign bus.DVLD = r_dvld;
        end
    endgenerate

    assign bus.FULL      = r_full;
    assign bus.EMPTY     = w_empty;
    assign bus.AFULL     = r_afull;
    assign bus.AEMPTY    = r_aempty;
    assign bus.COUNT     = r_count;
    assign bus.OVERFLOW  = r_ovf;
    assign bus.UNDERFLOW = r_udf;
endmodule
`default_nettype wire
